// File: rtl/alu_unit.sv
// 32-bit execute-stage ALU: opcode decode, combinational compute core and registered result/flags.
// Optional macro ALU_DIV_EN enables the single-cycle unsigned divider; without it DIVA yields 0.

module alu_core #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] result_o
);

  localparam logic [2:0] OpAdd = 3'b000;
  localparam logic [2:0] OpSub = 3'b001;
  localparam logic [2:0] OpMul = 3'b010;
  localparam logic [2:0] OpDiv = 3'b011;
  localparam logic [2:0] OpAnd = 3'b100;
  localparam logic [2:0] OpOr  = 3'b101;
  localparam logic [2:0] OpXor = 3'b110;
  localparam logic [2:0] OpNot = 3'b111;

  logic [WIDTH-1:0] quot;

`ifdef ALU_DIV_EN
  // Division by zero saturates to all ones.
  assign quot = (b_i == '0) ? '1 : (a_i / b_i);
`else
  assign quot = '0;
`endif

  always_comb begin
    result_o = '0;
    unique case (op)
      OpAdd:   result_o = a_i + b_i;
      OpSub:   result_o = a_i - b_i;
      OpMul:   result_o = a_i * b_i;
      OpDiv:   result_o = quot;
      OpAnd:   result_o = a_i & b_i;
      OpOr:    result_o = a_i | b_i;
      OpXor:   result_o = a_i ^ b_i;
      OpNot:   result_o = ~a_i;
      default: result_o = '0;
    endcase
  end

endmodule

module alu_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [4:0]       opcode,
  output logic [WIDTH-1:0] alu_out,
  output logic [1:0]       flags,
  output logic [2:0]       alu_op
);

  localparam logic [2:0] OpAdd = 3'b000;
  localparam logic [2:0] OpSub = 3'b001;
  localparam logic [2:0] OpMul = 3'b010;
  localparam logic [2:0] OpDiv = 3'b011;
  localparam logic [2:0] OpAnd = 3'b100;
  localparam logic [2:0] OpOr  = 3'b101;
  localparam logic [2:0] OpXor = 3'b110;
  localparam logic [2:0] OpNot = 3'b111;

  logic [2:0]       op_dec;
  logic             flag_en;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] alu_out_q, alu_out_d;
  logic [1:0]       flags_q, flags_d;

  // Only explicitly decoded opcodes update flags; branches/CALL/RET etc. hold them.
  always_comb begin
    op_dec  = OpAdd;
    flag_en = 1'b1;
    case (opcode)
      5'b00010, 5'b00011: op_dec = OpAdd;
      5'b00100, 5'b00101: op_dec = OpSub;
      5'b00110:           op_dec = OpMul;
      5'b01000:           op_dec = OpDiv;
      5'b01010, 5'b01011: op_dec = OpAnd;
      5'b01100, 5'b01101: op_dec = OpOr;
      5'b01110:           op_dec = OpNot;
      5'b10000, 5'b10001: op_dec = OpXor;
      5'b10010:           op_dec = OpSub;
      5'b11100, 5'b11101: op_dec = OpAdd;
      5'b00111, 5'b11110: op_dec = OpAnd;
      default: begin
        op_dec  = OpAdd;
        flag_en = 1'b0;
      end
    endcase
  end

  alu_core #(
    .WIDTH (WIDTH)
  ) ALU (
    .a_i      (a),
    .b_i      (b),
    .op       (op_dec),
    .result_o (result)
  );

  always_comb begin
    alu_out_d = result;
    flags_d   = flags_q;
    if (flag_en) begin
      flags_d = {(result == '0), result[WIDTH-1]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_out_q <= '0;
      flags_q   <= 2'b00;
    end else begin
      alu_out_q <= alu_out_d;
      flags_q   <= flags_d;
    end
  end

  assign alu_out = alu_out_q;
  assign flags   = flags_q;
  assign alu_op  = op_dec;

endmodule

// File: tb/tb_alu_unit.sv
// Directed self-checking bench for alu_unit: decode sweep, arithmetic/logic vectors,
// flag hold on default-mapped opcodes and asynchronous reset.

module tb_alu_unit;

  logic        clk;
  logic        rst_n;
  logic [31:0] a;
  logic [31:0] b;
  logic [4:0]  opcode;
  logic [31:0] alu_out;
  logic [1:0]  flags;
  logic [2:0]  alu_op;

  int unsigned n_checks;
  int unsigned n_fails;

  alu_unit #(
    .WIDTH (32)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .a       (a),
    .b       (b),
    .opcode  (opcode),
    .alu_out (alu_out),
    .flags   (flags),
    .alu_op  (alu_op)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Apply inputs on a falling edge, sample on the next falling edge (one rising edge between).
  task automatic run_op(input logic [4:0] opc, input logic [31:0] va, input logic [31:0] vb);
    @(negedge clk);
    opcode = opc;
    a      = va;
    b      = vb;
    @(negedge clk);
  endtask

  logic [4:0] dec_opc [24];
  logic [2:0] dec_exp [24];

  initial begin
    dec_opc = '{5'b00010, 5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b01000,
                5'b01010, 5'b01011, 5'b01100, 5'b01101, 5'b01110, 5'b10000,
                5'b10001, 5'b10010, 5'b11100, 5'b11101, 5'b00111, 5'b11110,
                5'b11001, 5'b11010, 5'b11011, 5'b00000, 5'b01111, 5'b11111};
    dec_exp = '{3'b000, 3'b000, 3'b001, 3'b001, 3'b010, 3'b011,
                3'b100, 3'b100, 3'b101, 3'b101, 3'b111, 3'b110,
                3'b110, 3'b001, 3'b000, 3'b000, 3'b100, 3'b100,
                3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000};

    n_checks = 0;
    n_fails  = 0;
    rst_n    = 1'b0;
    a        = 32'h0;
    b        = 32'h0;
    opcode   = 5'b00010;

    #12;
    check_eq("reset_alu_out", alu_out, 32'h0);
    check_eq("reset_flags", {30'h0, flags}, 32'h0);
    opcode = 5'b01110;
    #1;
    check_eq("reset_alu_op_comb", {29'h0, alu_op}, 32'h7);

    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      opcode = dec_opc[i];
      a      = 32'h1234_5678;
      b      = 32'h0000_0011;
      @(negedge clk);
      @(negedge clk);
      check_eq($sformatf("decode_alu_op_%b", dec_opc[i]), {29'h0, alu_op}, {29'h0, dec_exp[i]});
      check_eq($sformatf("decode_ALU_op_%b", dec_opc[i]), {29'h0, dut.ALU.op},
               {29'h0, dec_exp[i]});
    end

    run_op(5'b00100, 32'h0000_0005, 32'h0000_0005);
    check_eq("sub_zero_out", alu_out, 32'h0);
    check_eq("sub_zero_flags", {30'h0, flags}, 32'h2);

    run_op(5'b00010, 32'hFFFF_FFFF, 32'h0000_0001);
    check_eq("add_wrap_out", alu_out, 32'h0);
    check_eq("add_wrap_flags", {30'h0, flags}, 32'h2);

    run_op(5'b10010, 32'd3, 32'd7);
    check_eq("cmp_neg_out", alu_out, 32'hFFFF_FFFC);
    check_eq("cmp_neg_flags", {30'h0, flags}, 32'h1);

    // CALL: result follows a+b but flags must keep the CMP value.
    run_op(5'b11001, 32'h0, 32'h0);
    check_eq("call_out", alu_out, 32'h0);
    check_eq("call_flags_hold", {30'h0, flags}, 32'h1);

    run_op(5'b00110, 32'h0001_0000, 32'h0001_0000);
    check_eq("mul_overflow_out", alu_out, 32'h0);
    check_eq("mul_overflow_flags", {30'h0, flags}, 32'h2);

    run_op(5'b00110, 32'h0000_1234, 32'h0000_0010);
    check_eq("mul_out", alu_out, 32'h0001_2340);

`ifdef ALU_DIV_EN
    run_op(5'b01000, 32'd100, 32'd7);
    check_eq("div_out", alu_out, 32'd14);
    check_eq("div_flags", {30'h0, flags}, 32'h0);
    run_op(5'b01000, 32'd100, 32'd0);
    check_eq("div_zero_out", alu_out, 32'hFFFF_FFFF);
    check_eq("div_zero_flags", {30'h0, flags}, 32'h1);
`else
    run_op(5'b01000, 32'd100, 32'd7);
    check_eq("div_off_out", alu_out, 32'h0);
    check_eq("div_off_flags", {30'h0, flags}, 32'h2);
    run_op(5'b01000, 32'd100, 32'd0);
    check_eq("div_zero_off_out", alu_out, 32'h0);
`endif

    run_op(5'b01100, 32'hF000_0000, 32'h0000_000F);
    check_eq("or_out", alu_out, 32'hF000_000F);
    check_eq("or_flags", {30'h0, flags}, 32'h1);

    run_op(5'b10001, 32'hAAAA_5555, 32'hFFFF_0000);
    check_eq("xor_out", alu_out, 32'h5555_5555);

    run_op(5'b01110, 32'h0F0F_0000, 32'hDEAD_BEEF);
    check_eq("not_out", alu_out, 32'hF0F0_FFFF);

    run_op(5'b01010, 32'hF0F0_F0F0, 32'h0FF0_0000);
    check_eq("and_out", alu_out, 32'h00F0_0000);
    check_eq("and_flags", {30'h0, flags}, 32'h0);

    run_op(5'b11001, 32'h0, 32'h0);
    check_eq("call_zero_out", alu_out, 32'h0);
    check_eq("call_zero_flags_hold", {30'h0, flags}, 32'h0);

    run_op(5'b00100, 32'd1, 32'd2);
    check_eq("pre_reset_out", alu_out, 32'hFFFF_FFFF);
    check_eq("pre_reset_flags", {30'h0, flags}, 32'h1);

    // Async reset between edges: outputs must clear without a clock edge.
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("async_reset_out", alu_out, 32'h0);
    check_eq("async_reset_flags", {30'h0, flags}, 32'h0);
    @(negedge clk);
    check_eq("reset_held_out", alu_out, 32'h0);
    rst_n = 1'b1;

    run_op(5'b00011, 32'h0000_0010, 32'h0000_0020);
    check_eq("post_reset_out", alu_out, 32'h0000_0030);
    check_eq("post_reset_flags", {30'h0, flags}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/alu_unit.md
Name: alu_unit

Overview:
- 32-bit integer ALU for the CPU execute stage.
- Decodes the 5-bit instruction opcode into a 3-bit internal ALU operation, computes the result from operands a/b, and registers the result and a 2-bit condition-flag vector.
- The decode is combinational and exported for verification. The result path has 1-cycle latency.

Parameters:
- WIDTH, 32, operand/result width (only 32 is verified).

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- a  input  WIDTH  operand A (register source 1).
- b  input  WIDTH  operand B (register source 2 or immediate, pre-extended/masked by datapath).
- opcode  input  5  instruction opcode.
- alu_out  output  WIDTH  registered result.
- flags  output  2  registered flags: flags[1]=Z (result==0), flags[0]=N (result[31]).
- alu_op  output  3  combinational decoded ALU operation (debug/verification).

Behaviour:
- Interface: one clock clk; reset rst_n is asynchronous, active-low.
- Internal compute submodule instance is named ALU; its operation input/signal is named op and equals alu_op. Benches probe it hierarchically.
- ALU op encoding: ADDA=000, SUBA=001, MULA=010, DIVA=011, ANDA=100, ORA=101, XORA=110, NOTA=111.
- Opcode decode (combinational, no clock dependency):
  - 00010 ADD, 00011 ADDI -> ADDA.
  - 00100 SUB, 00101 SUBI -> SUBA.
  - 00110 MUL -> MULA.
  - 01000 DIV -> DIVA.
  - 01010 AND, 01011 ANDI -> ANDA.
  - 01100 OR, 01101 ORI -> ORA.
  - 01110 NOT -> NOTA.
  - 10000 XOR, 10001 XORI -> XORA.
  - 10010 CMP -> SUBA.
  - 11100 ST, 11101 LD -> ADDA (address calc).
  - 00111 MOVEH, 11110 MOVEL -> ANDA.
  - All other opcodes (branches, CALL 11001, RET 11010, RETI 11011, unused) -> ADDA.
- Compute:
  - ADD: a+b mod 2^32.
  - SUB: a-b mod 2^32.
  - MUL: unsigned product, low 32 bits.
  - DIV: unsigned a/b; b==0 -> 32'hFFFF_FFFF.
  - AND/OR/XOR: bitwise.
  - NOT: ~a (b ignored).
- Registers: on each rising clk, alu_out <= result.
  - flags update only for opcodes explicitly listed in the decode table above (including CMP, LD, ST, MOVEH, MOVEL); for the default-mapped opcodes flags hold their value.
- Z = (result == 0); N = result[31].
- Reset: alu_out=0, flags=2'b00 immediately on rst_n low, held while low. alu_op stays combinational during reset.
- Latency: result for inputs sampled at edge k visible after edge k. Back-to-back ops every cycle, no stalls, no handshake.
- Reset deasserting mid-stream: the first edge with rst_n high captures current inputs normally.

Optional Feature:
- Macro ALU_DIV_EN.
- Defined: DIVA performs unsigned division as above, single-cycle combinational divider.
- Undefined: no divider hardware; DIVA yields result 0 (flags Z=1, N=0). Decode of DIV still produces alu_op=011.

Test Plan:
- Decode sweep: apply each listed opcode, wait 2 clk edges -> alu_op/ALU.op matches table (e.g. CMP 10010 -> 001, MOVEL 11110 -> 100, LD 11101 -> 000, NOT 01110 -> 111).
- Add/sub: a=32'h0000_0005, b=32'h0000_0005, opcode SUB -> next edge alu_out=0, flags=2'b10. Then ADD a=32'hFFFF_FFFF, b=1 -> alu_out=0, flags=2'b10.
- Negative: CMP a=3, b=7 -> alu_out=32'hFFFF_FFFC, flags=2'b01.
- Mul/div: MUL a=32'h0001_0000, b=32'h0001_0000 -> alu_out=0. DIV a=100, b=7 -> 14. DIV b=0 -> 32'hFFFF_FFFF with ALU_DIV_EN defined, 0 otherwise.
- Logic/hold: AND a=32'hF0F0_F0F0, b=32'h0FF0_0000 -> 32'h00F0_0000, flags 00. Then CALL (11001) with a=b=0 -> alu_out=0, flags remain 00.
- Async reset: assert rst_n low between edges after a nonzero result -> alu_out=0, flags=00 immediately without a clock edge. Release rst_n -> next edge resumes normal operation.
